uart_challenge_assembler: RTL and testbench
===========================================

// Module: uart_challenge_assembler
// PURPOSE
//  Sits directly downstream of the uart receiver (received/rx_byte/recv_error).
//  Packs num_bytes consecutive received bytes into one challenge word for the PUF core.
//  Presents the word on a valid/ready handshake.
//  Discards partial frames on line error or inter-byte timeout.
// PARAMETERS
//  num_bytes       8          bytes per challenge frame (>=1)
//  sys_clk_freq    100000000  master clock frequency, Hz
//  timeout_cycles  5208000    idle clocks between bytes before a partial frame is dropped (~100 UART bytes at 19200 baud)
// PORTS
//  clk              in   1              master clock
//  rst              in   1              synchronous reset, active high
//  received         in   1              1-cycle strobe from uart: rx_byte valid
//  rx_byte          in   8              byte from uart
//  recv_error       in   1              1-cycle strobe from uart: framing error
//  challenge        out  num_bytes*8    assembled frame; first received byte in [7:0]
//  challenge_valid  out  1              frame complete and held
//  challenge_ready  in   1              consumer accepts frame when valid&&ready
//  byte_count       out  $clog2(num_bytes+1)  bytes collected in the current frame
//  frame_dropped    out  1              1-cycle pulse: partial frame discarded (error or timeout)
//  overrun          out  1              1-cycle pulse: byte arrived while HOLD and not accepted
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - state=IDLE; challenge=0, challenge_valid=0, byte_count=0, frame_dropped=0, overrun=0; timer=0.
//   - Reset mid-frame or in HOLD discards everything; no pulse is issued.
//  States: IDLE, COLLECT, HOLD.
//  IDLE:
//   - received: store rx_byte at challenge[7:0], byte_count=1, go to COLLECT.
//   - If num_bytes==1, go to HOLD instead.
//  COLLECT:
//   - received: store at byte lane byte_count, byte_count+1, clear timer.
//   - Last byte goes to HOLD. challenge_valid is high the cycle after the last received strobe (latency 1).
//   - No byte this cycle: timer+1.
//   - Timer reaches timeout_cycles-1: pulse frame_dropped, byte_count=0, go to IDLE. challenge lanes are not cleared.
//   - recv_error: pulse frame_dropped, byte_count=0, go to IDLE.
//  recv_error in IDLE: ignored (no pulse).
//  HOLD:
//   - challenge_valid=1; challenge stable until transfer; byte_count=num_bytes.
//   - valid&&ready: challenge_valid=0 next cycle, byte_count=0, go to IDLE.
//   - received without transfer in the same cycle: byte dropped, overrun pulses.
//   - recv_error in HOLD: ignored (frame already complete).
//  Simultaneous events:
//   - received & recv_error in COLLECT: error wins, byte discarded, frame_dropped pulses.
//   - HOLD with transfer and received in the same cycle: transfer completes. rx_byte becomes byte 0 of the next frame; state=COLLECT (HOLD if num_bytes==1); no overrun.
//  Timer: width $clog2(timeout_cycles+1); saturates; runs only in COLLECT.
//  Lane index: byte_count, range 0..num_bytes-1; never wraps past num_bytes.
// STRUCTURE
//  Shared package: state encodings (IDLE/COLLECT/HOLD) and UART_BAUD=19200.
//  Shared package: the default timeout_cycles derivation from sys_clk_freq/baud.
//  One sub-module: uart_idle_timer (clear, enable, expire pulse at timeout_cycles-1).
//  The byte-lane shift/write logic and FSM live in this module.
// TESTING
//  T1: after rst, send 8 bytes 01..08 with ready=0 -> challenge=64'h0807060504030201.
//      challenge_valid rises 1 cycle after the 8th strobe; byte_count=8.
//  T2: T1 state, raise ready for 1 cycle -> valid drops next cycle; byte_count=0.
//      Next byte AA lands in [7:0].
//  T3: send 3 bytes, then hold received low for timeout_cycles -> one frame_dropped pulse; byte_count=0.
//      The following 8 bytes form a clean frame.
//  T4: send 5 bytes, then recv_error together with a received strobe -> frame_dropped pulses; byte not stored.
//      byte_count=0.
//  T5: in HOLD with ready=0, strobe byte 55 -> overrun pulses; challenge unchanged.
//      Same with ready=1 in that cycle -> no overrun; 55 becomes byte 0; byte_count=1.
//  T6: assert rst during COLLECT (byte_count=4) and during HOLD -> all outputs 0 the next cycle; no pulses.

Source files
------------

// File: rtl/uart_challenge_assembler_pkg.sv
// Shared definitions for the UART challenge assembler slice.
//
// Contents:
//   state_e               - assembler FSM encoding (IDLE / COLLECT / HOLD)
//   UART_BAUD             - line rate the idle timeout is derived from
//   defaultTimeoutCycles  - clocks that ~100 UART bytes occupy at UART_BAUD
package uart_challenge_assembler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  localparam int UART_BAUD          = 19200;
  localparam int UART_BITS_PER_BYTE = 10;
  localparam int TIMEOUT_BYTES      = 100;

  // One UART byte is start + 8 data + stop = 10 bit times; the timeout
  // allows roughly 100 byte times of silence before dropping a partial frame.
  function automatic int defaultTimeoutCycles(input int clkFreq);
    return (clkFreq / UART_BAUD) * UART_BITS_PER_BYTE * TIMEOUT_BYTES;
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer for the challenge assembler.
//
// Counts enabled cycles since the last clear and flags the cycle in which
// the count reaches timeout_cycles-1. The counter saturates so it can never
// wrap back into the expire window.
//
// Ports:
//   clk_i     master clock
//   rst_i     synchronous reset, active high
//   clear_i   restart the count at zero (takes priority over enable_i)
//   enable_i  count this cycle
//   expire_o  combinational: enabled, not cleared, count == timeout_cycles-1
module uart_idle_timer
  import uart_challenge_assembler_pkg::*;
#(
  parameter int timeout_cycles = 5208000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int            TW   = $clog2(timeout_cycles + 1);
  localparam logic [TW-1:0] LAST = TW'(timeout_cycles - 1);
  localparam logic [TW-1:0] SAT  = TW'(timeout_cycles);

  logic [TW-1:0] count_q, count_d;

  // Next count: clear wins, otherwise increment while enabled until the
  // saturation value is reached.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != SAT)) begin
      count_d = count_q + TW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/uart_challenge_assembler.sv
// Packs num_bytes consecutive UART bytes into one PUF challenge word.
//
// The first byte of a frame lands in challenge[7:0], the next in [15:8],
// and so on. A complete frame is held on a valid/ready handshake. Partial
// frames are discarded on a framing error or after a long idle gap.
//
// Ports:
//   clk              master clock
//   rst              synchronous reset, active high
//   received         1-cycle strobe: rx_byte is valid
//   rx_byte          byte from the UART receiver
//   recv_error       1-cycle strobe: UART framing error
//   challenge        assembled frame, first byte in [7:0]
//   challenge_valid  frame complete and held
//   challenge_ready  consumer accepts the frame when valid && ready
//   byte_count       bytes collected in the current frame
//   frame_dropped    1-cycle pulse: partial frame discarded
//   overrun          1-cycle pulse: byte arrived while holding an unaccepted frame
module uart_challenge_assembler
  import uart_challenge_assembler_pkg::*;
#(
  parameter int num_bytes      = 8,
  parameter int sys_clk_freq   = 100000000,
  parameter int timeout_cycles = defaultTimeoutCycles(sys_clk_freq)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           received,
  input  logic [7:0]                     rx_byte,
  input  logic                           recv_error,
  output logic [num_bytes*8-1:0]         challenge,
  output logic                           challenge_valid,
  input  logic                           challenge_ready,
  output logic [$clog2(num_bytes+1)-1:0] byte_count,
  output logic                           frame_dropped,
  output logic                           overrun
);

  localparam int            CW   = $clog2(num_bytes + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] FULL = CW'(num_bytes);

  state_e                 state_q, state_d;
  logic [num_bytes*8-1:0] challenge_q, challenge_d;
  logic [CW-1:0]          byteCount_q, byteCount_d;
  logic                   frameDropped_q, frameDropped_d;
  logic                   overrun_q, overrun_d;

  logic timerClear;
  logic timerEnable;
  logic timerExpire;

  // The idle timer only runs while a partial frame is open; any byte or
  // error restarts it, and every other state keeps it parked at zero so a
  // new frame always starts with a fresh timeout window.
  assign timerEnable = (state_q == COLLECT);
  assign timerClear  = (state_q != COLLECT) || received || recv_error;

  uart_idle_timer #(
    .timeout_cycles(timeout_cycles)
  ) idleTimer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (timerClear),
    .enable_i(timerEnable),
    .expire_o(timerExpire)
  );

  // Next-state and datapath update. Byte lanes are written at the index
  // given by the current byte count; lanes of a dropped frame are left
  // stale rather than cleared since they are overwritten before the next
  // frame becomes valid. In HOLD a transfer and a new byte in the same
  // cycle hand the byte straight to the next frame without an overrun.
  always_comb begin
    state_d        = state_q;
    challenge_d    = challenge_q;
    byteCount_d    = byteCount_q;
    frameDropped_d = 1'b0;
    overrun_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (received) begin
          challenge_d[7:0] = rx_byte;
          byteCount_d      = ONE;
          if (num_bytes == 1) state_d = HOLD;
          else                state_d = COLLECT;
        end
      end

      COLLECT: begin
        if (recv_error) begin
          frameDropped_d = 1'b1;
          byteCount_d    = '0;
          state_d        = IDLE;
        end else if (received) begin
          for (int i = 0; i < num_bytes; i++) begin
            if (byteCount_q == CW'(i)) challenge_d[i*8 +: 8] = rx_byte;
          end
          byteCount_d = byteCount_q + ONE;
          if ((byteCount_q + ONE) == FULL) state_d = HOLD;
        end else if (timerExpire) begin
          frameDropped_d = 1'b1;
          byteCount_d    = '0;
          state_d        = IDLE;
        end
      end

      HOLD: begin
        if (challenge_ready) begin
          byteCount_d = '0;
          state_d     = IDLE;
          if (received) begin
            challenge_d[7:0] = rx_byte;
            byteCount_d      = ONE;
            if (num_bytes == 1) state_d = HOLD;
            else                state_d = COLLECT;
          end
        end else if (received) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        byteCount_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      challenge_q    <= '0;
      byteCount_q    <= '0;
      frameDropped_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      challenge_q    <= challenge_d;
      byteCount_q    <= byteCount_d;
      frameDropped_q <= frameDropped_d;
      overrun_q      <= overrun_d;
    end
  end

  assign challenge       = challenge_q;
  assign challenge_valid = (state_q == HOLD);
  assign byte_count      = byteCount_q;
  assign frame_dropped   = frameDropped_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_uart_challenge_assembler.sv
// Directed self-checking bench for uart_challenge_assembler (8-byte frames,
// shortened 20-cycle idle timeout).
module tb_uart_challenge_assembler;

  localparam int NB = 8;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          received;
  logic [7:0]    rx_byte;
  logic          recv_error;
  logic          challenge_ready;
  logic [63:0]   challenge;
  logic          challenge_valid;
  logic [3:0]    byte_count;
  logic          frame_dropped;
  logic          overrun;

  int total = 0;
  int bad   = 0;

  uart_challenge_assembler #(
    .num_bytes     (NB),
    .sys_clk_freq  (100000000),
    .timeout_cycles(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .received       (received),
    .rx_byte        (rx_byte),
    .recv_error     (recv_error),
    .challenge      (challenge),
    .challenge_valid(challenge_valid),
    .challenge_ready(challenge_ready),
    .byte_count     (byte_count),
    .frame_dropped  (frame_dropped),
    .overrun        (overrun)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, let the edge happen, then sample 1ns later.
  task automatic applyStimulus(input logic rcv, input logic [7:0] b,
                               input logic err, input logic rdy);
    received        = rcv;
    rx_byte         = b;
    recv_error      = err;
    challenge_ready = rdy;
    @(posedge clk);
    #1;
    received        = 1'b0;
    recv_error      = 1'b0;
    challenge_ready = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Back-to-back byte strobes first, first+1, ... with ready low.
  task automatic sendBytes(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, first + 8'(i), 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; received = 1'b0; rx_byte = 8'h00; recv_error = 1'b0;
    challenge_ready = 1'b0;

    // Reset state.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("rst_challenge", challenge, 64'h0);
    checkOutput("rst_valid", 64'(challenge_valid), 64'd0);
    checkOutput("rst_count", 64'(byte_count), 64'd0);
    checkOutput("rst_dropped", 64'(frame_dropped), 64'd0);
    checkOutput("rst_overrun", 64'(overrun), 64'd0);

    // T1: eight bytes 01..08.
    sendBytes(8'h01, 7);
    checkOutput("t1_valid_7", 64'(challenge_valid), 64'd0);
    checkOutput("t1_count_7", 64'(byte_count), 64'd7);
    applyStimulus(1'b1, 8'h08, 1'b0, 1'b0);
    checkOutput("t1_valid_8", 64'(challenge_valid), 64'd1);
    checkOutput("t1_challenge", challenge, 64'h0807060504030201);
    checkOutput("t1_count_8", 64'(byte_count), 64'd8);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t1_valid_hold", 64'(challenge_valid), 64'd1);

    // T2: one-cycle ready, then AA starts the next frame in lane 0.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t2_valid_drop", 64'(challenge_valid), 64'd0);
    checkOutput("t2_count_zero", 64'(byte_count), 64'd0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("t2_aa_lane0", challenge, 64'h08070605040302AA);
    checkOutput("t2_count_one", 64'(byte_count), 64'd1);

    // T3: three bytes then silence until the timeout drops the frame.
    sendBytes(8'hBB, 2);
    checkOutput("t3_count_3", 64'(byte_count), 64'd3);
    for (int i = 0; i < TO - 1; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t3_no_drop_early", 64'(frame_dropped), 64'd0);
    checkOutput("t3_count_before", 64'(byte_count), 64'd3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t3_dropped", 64'(frame_dropped), 64'd1);
    checkOutput("t3_count_cleared", 64'(byte_count), 64'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t3_drop_pulse_end", 64'(frame_dropped), 64'd0);
    sendBytes(8'h11, 8);
    checkOutput("t3_clean_frame", challenge, 64'h1817161514131211);
    checkOutput("t3_clean_valid", 64'(challenge_valid), 64'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // T4: five bytes then error coinciding with a byte strobe.
    sendBytes(8'h21, 5);
    checkOutput("t4_count_5", 64'(byte_count), 64'd5);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    checkOutput("t4_dropped", 64'(frame_dropped), 64'd1);
    checkOutput("t4_count_zero", 64'(byte_count), 64'd0);
    checkOutput("t4_byte_not_stored", challenge, 64'h1817162524232221);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t4_idle_error_ignored", 64'(frame_dropped), 64'd0);

    // T5: overrun in HOLD, then transfer with a simultaneous byte.
    sendBytes(8'h31, 8);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("t5_overrun", 64'(overrun), 64'd1);
    checkOutput("t5_challenge_kept", challenge, 64'h3837363534333231);
    checkOutput("t5_still_valid", 64'(challenge_valid), 64'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t5_overrun_end", 64'(overrun), 64'd0);
    checkOutput("t5_hold_error_ignored", 64'(frame_dropped), 64'd0);
    checkOutput("t5_hold_after_error", 64'(challenge_valid), 64'd1);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
    checkOutput("t5_no_overrun", 64'(overrun), 64'd0);
    checkOutput("t5_count_one", 64'(byte_count), 64'd1);
    checkOutput("t5_valid_drop", 64'(challenge_valid), 64'd0);
    checkOutput("t5_55_lane0", challenge, 64'h3837363534333255);

    // T6: reset mid-frame and in HOLD.
    sendBytes(8'h41, 3);
    checkOutput("t6_count_4", 64'(byte_count), 64'd4);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("t6_collect_rst_chal", challenge, 64'h0);
    checkOutput("t6_collect_rst_count", 64'(byte_count), 64'd0);
    checkOutput("t6_collect_rst_drop", 64'(frame_dropped), 64'd0);
    sendBytes(8'h61, 8);
    checkOutput("t6_hold_reached", 64'(challenge_valid), 64'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("t6_hold_rst_valid", 64'(challenge_valid), 64'd0);
    checkOutput("t6_hold_rst_chal", challenge, 64'h0);
    checkOutput("t6_hold_rst_count", 64'(byte_count), 64'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t6_no_drop_after", 64'(frame_dropped), 64'd0);
    checkOutput("t6_no_overrun_after", 64'(overrun), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
